jk_excitation_driver: RTL
=========================

JK_EXCITATION_DRIVER -- requirements
Module: jk_excitation_driver

Interface
REQ-001 The block SHALL take parameter WIDTH, default 4: number of external JK flip-flops driven, range 1..16.
REQ-002 The block SHALL take parameter MAX_RETRY, default 3: number of re-drives allowed after the first drive, range 0..3.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, all logic on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port tgt_valid, input, 1 bit: target request valid.
REQ-006 The block SHALL have port tgt_data, input, WIDTH bits: requested flip-flop state.
REQ-007 The block SHALL have port tgt_mode, input, 1 bit: 0 selects set/reset encoding, 1 selects toggle encoding.
REQ-008 The block SHALL have port tgt_ready, output, 1 bit: request accepted when high together with tgt_valid.
REQ-009 The block SHALL have port q_fb, input, WIDTH bits: q feedback from the external JK bank.
REQ-010 The block SHALL have ports j and k, outputs, WIDTH bits each: excitation to the JK bank.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle success pulse.
REQ-012 The block SHALL have port err, output, 1 bit: sticky failure flag.
REQ-013 The block SHALL have port retry_cnt, output, 2 bits: re-drives used on the current or last request.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, DRIVE, CHECK, DONE, ERROR.
REQ-015 IDLE: tgt_ready=1, j=k=0; on tgt_valid&&tgt_ready, capture tgt_data/tgt_mode, clear err and retry_cnt, go DRIVE.
REQ-016 tgt_ready SHALL be 0 in every non-IDLE state; tgt_valid outside IDLE is ignored and no request is queued.
REQ-017 j/k SHALL be registered, loaded on the edge entering DRIVE, from q_fb at that edge and the captured target (tgt_data directly on entry from IDLE).
REQ-018 Mode 0, per bit, current->target: 0->0 J=0 K=0; 0->1 J=1 K=0; 1->0 J=0 K=1; 1->1 J=0 K=0.
REQ-019 Mode 1, per bit: J=K=1 when q_fb differs from target; otherwise J=K=0.
REQ-020 DRIVE SHALL last exactly one cycle, then go CHECK; j/k SHALL return to 0 on the edge leaving DRIVE.
REQ-021 CHECK: if q_fb==target, go DONE; else if retry_cnt<MAX_RETRY, increment retry_cnt and go DRIVE; else go ERROR.
REQ-022 DONE SHALL assert done=1 for one cycle, then go IDLE.
REQ-023 ERROR SHALL set err=1 and go IDLE next cycle; err holds until the next accept or reset.
REQ-024 Latency: accept at edge E0 gives DRIVE in E0..E1, CHECK in E1..E2, and done=1 in E2..E3 when the first drive succeeds; each retry adds 2 cycles.
REQ-025 A target equal to q_fb at accept SHALL still pass through DRIVE, with j=k=0.
REQ-026 done and err SHALL never be 1 in the same cycle.

Reset
REQ-027 reset SHALL take effect on the next rising edge, in any state including mid-DRIVE/CHECK, and override tgt_valid.
REQ-028 After reset the outputs SHALL be: state=IDLE, tgt_ready=1, j=0, k=0, done=0, err=0, retry_cnt=0, captured target=0.
REQ-029 No done pulse SHALL be produced for a request aborted by reset.

Verification (WIDTH=4, MAX_RETRY=3, bench models a JK bank on q_fb)
REQ-030 Reset scenario: reset 1 for 2 cycles -> tgt_ready=1, j=0000, k=0000, done=0, err=0, retry_cnt=00.
REQ-031 Mode 0 scenario: q_fb=0110, tgt=1010, tgt_mode=0 -> DRIVE j=1000, k=0100; bank yields 1010; done=1 in E2..E3; retry_cnt=00.
REQ-032 Mode 1 scenario: q_fb=1100, tgt=0110, tgt_mode=1 -> j=1010, k=1010; bank yields 0110; done pulse.
REQ-033 Stuck-bank scenario: q_fb held 0000, tgt=0001 -> 4 DRIVE cycles with j=0001, err=1, retry_cnt=11, done never asserted.
REQ-034 Abort scenario: reset asserted during CHECK -> next cycle IDLE, j=k=0000, no done; then tgt_valid held high in DRIVE -> tgt_ready=0 and the request is not accepted until IDLE.

Source files
------------

// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: drives a bank of external JK flip-flops towards a requested
// state, checks the q feedback after each drive, and re-drives a bounded number of
// times before reporting failure through a sticky error flag.
module jk_excitation_driver #(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic             tgt_mode,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             done,
    output logic             err,
    output logic [1:0]       retry_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);

    state_t           state;
    logic [WIDTH-1:0] target;
    logic             mode;

    // Excitation for the current q towards the target: set/reset in mode 0, toggle in mode 1.
    function automatic logic [2*WIDTH-1:0] excite(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] tgt,
        input logic             tog
    );
        logic [WIDTH-1:0] jv;
        logic [WIDTH-1:0] kv;
        if (tog) begin
            jv = cur ^ tgt;
            kv = cur ^ tgt;
        end else begin
            jv = tgt & ~cur;
            kv = cur & ~tgt;
        end
        return {jv, kv};
    endfunction

    // Request sequencing: accept, drive for one cycle, verify feedback, retry or finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tgt_ready <= 1'b1;
            j         <= '0;
            k         <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            retry_cnt <= 2'd0;
            target    <= '0;
            mode      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tgt_valid && tgt_ready) begin
                        target    <= tgt_data;
                        mode      <= tgt_mode;
                        err       <= 1'b0;
                        retry_cnt <= 2'd0;
                        {j, k}    <= excite(q_fb, tgt_data, tgt_mode);
                        tgt_ready <= 1'b0;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    j     <= '0;
                    k     <= '0;
                    state <= CHECK;
                end
                CHECK: begin
                    if (q_fb == target) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (retry_cnt < RETRY_LIMIT) begin
                        retry_cnt <= retry_cnt + 2'd1;
                        {j, k}    <= excite(q_fb, target, mode);
                        state     <= DRIVE;
                    end else begin
                        err   <= 1'b1;
                        state <= ERROR;
                    end
                end
                DONE: begin
                    tgt_ready <= 1'b1;
                    state     <= IDLE;
                end
                ERROR: begin
                    tgt_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    j         <= '0;
                    k         <= '0;
                    tgt_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
